// File: rtl/idu_pipe_if.sv
// Fetch-to-execute decode stage bus: instruction/operand inputs from the IFU and
// register file, decoded bundle towards the EXU, each side with valid/ready.
interface idu_pipe_if #(parameter int DATA_LEN = 32);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         inst;
  logic [DATA_LEN-1:0] PC;
  logic [DATA_LEN-1:0] PC_S;
  logic [DATA_LEN-1:0] src1;
  logic [DATA_LEN-1:0] src2;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic                out_valid;
  logic                out_ready;
  logic [4:0]          rd;
  logic                rd_we;
  logic [DATA_LEN-1:0] operand1;
  logic [DATA_LEN-1:0] operand2;
  logic [DATA_LEN-1:0] operand3;
  logic [DATA_LEN-1:0] operand4;
  logic [DATA_LEN-1:0] imm;
  logic [3:0]          alu_op;
  logic [2:0]          funct3;
  logic                jump;
  logic                branch;
  logic                load;
  logic                store;
  logic                word_op;
  logic                ecall;
  logic                ebreak;
  logic                illegal;

  modport master (
    output in_valid, inst, PC, PC_S, src1, src2, out_ready,
    input  in_ready, rs1, rs2, out_valid, rd, rd_we, operand1, operand2, operand3,
           operand4, imm, alu_op, funct3, jump, branch, load, store, word_op,
           ecall, ebreak, illegal
  );

  modport slave (
    input  in_valid, inst, PC, PC_S, src1, src2, out_ready,
    output in_ready, rs1, rs2, out_valid, rd, rd_we, operand1, operand2, operand3,
           operand4, imm, alu_op, funct3, jump, branch, load, store, word_op,
           ecall, ebreak, illegal
  );
endinterface

// File: rtl/idu_pipe.sv
// Registered RV32I/RV64I decode stage: combinational decode of the incoming word
// into operands and class flags, captured in a valid/ready pipeline register.
module idu_pipe #(
  parameter int DATA_LEN = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  idu_pipe_if.slave bus
);
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam bit         XLEN64      = (DATA_LEN == 64);

  typedef struct packed {
    logic [4:0]          rd;
    logic                rd_we;
    logic [DATA_LEN-1:0] operand1;
    logic [DATA_LEN-1:0] operand2;
    logic [DATA_LEN-1:0] operand3;
    logic [DATA_LEN-1:0] operand4;
    logic [DATA_LEN-1:0] imm;
    logic [3:0]          alu_op;
    logic [2:0]          funct3;
    logic                jump;
    logic                branch;
    logic                load;
    logic                store;
    logic                word_op;
    logic                ecall;
    logic                ebreak;
    logic                illegal;
  } dec_t;

  dec_t                d;
  dec_t                q;
  logic                valid_q;
  logic                accept;
  logic [31:0]         inst;
  logic [6:0]          opc;
  logic [2:0]          f3;
  logic [DATA_LEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic                is_shift, f7_ok, f6_ok, we, bad;

  assign inst  = bus.inst;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign imm_i = DATA_LEN'($signed(inst[31:20]));
  assign imm_s = DATA_LEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = DATA_LEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = DATA_LEN'($signed({inst[31:12], 12'h000}));
  assign imm_j = DATA_LEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign f7_ok    = (inst[31:25] == 7'h00) || (inst[31:25] == 7'h20);
  // RV64 non-word immediate shifts carry a 6-bit shamt, so inst[25] is data
  assign f6_ok    = (inst[31:26] == 6'h00) || (inst[31:26] == 6'h10);

  always_comb begin
    d        = '0;
    d.rd     = inst[11:7];
    d.funct3 = f3;
    we       = 1'b0;
    bad      = 1'b0;
    case (opc)
      OPC_LUI: begin
        d.operand2 = imm_u; d.imm = imm_u; we = 1'b1;
      end
      OPC_AUIPC: begin
        d.operand1 = bus.PC; d.operand2 = imm_u; d.imm = imm_u; we = 1'b1;
      end
      OPC_JAL: begin
        d.operand1 = bus.PC_S; d.operand3 = bus.PC; d.operand4 = imm_j;
        d.imm = imm_j; d.jump = 1'b1; we = 1'b1;
      end
      OPC_JALR: begin
        d.operand1 = bus.PC_S; d.operand3 = bus.src1; d.operand4 = imm_i;
        d.imm = imm_i; d.jump = 1'b1; we = 1'b1;
      end
      OPC_BRANCH: begin
        d.operand1 = bus.src1; d.operand2 = bus.src2; d.operand3 = bus.PC;
        d.operand4 = imm_b; d.imm = imm_b; d.branch = 1'b1; d.alu_op = {1'b0, f3};
      end
      OPC_LOAD: begin
        d.operand1 = bus.src1; d.operand2 = imm_i; d.imm = imm_i;
        d.load = 1'b1; we = 1'b1;
      end
      OPC_STORE: begin
        d.operand1 = bus.src1; d.operand2 = imm_s; d.operand3 = bus.src2;
        d.imm = imm_s; d.store = 1'b1;
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        if (opc == OPC_OPIMM32 && !XLEN64) begin
          bad = 1'b1;
        end else begin
          d.operand1 = bus.src1; d.operand2 = imm_i; d.imm = imm_i;
          d.alu_op   = {(f3 == 3'b101) && inst[30], f3};
          d.word_op  = (opc == OPC_OPIMM32);
          we         = 1'b1;
          if (is_shift && !((XLEN64 && opc == OPC_OPIMM) ? f6_ok : f7_ok)) bad = 1'b1;
        end
      end
      OPC_OP, OPC_OP32: begin
        if (opc == OPC_OP32 && !XLEN64) begin
          bad = 1'b1;
        end else begin
          d.operand1 = bus.src1; d.operand2 = bus.src2;
          d.alu_op   = {inst[30], f3};
          d.word_op  = (opc == OPC_OP32);
          we         = 1'b1;
          if (!f7_ok) bad = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (inst == 32'h0000_0073)      d.ecall  = 1'b1;
        else if (inst == 32'h0010_0073) d.ebreak = 1'b1;
        else                            bad      = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) bad = 1'b1;
    if (bad) begin
      d         = '0;
      d.rd      = inst[11:7];
      d.funct3  = f3;
      d.illegal = 1'b1;
    end else begin
      d.rd_we = we && (inst[11:7] != 5'd0);
    end
  end

  assign bus.in_ready = !flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      q       <= d;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.rs1       = inst[19:15];
  assign bus.rs2       = inst[24:20];
  assign bus.out_valid = valid_q;
  assign bus.rd        = q.rd;
  assign bus.rd_we     = q.rd_we;
  assign bus.operand1  = q.operand1;
  assign bus.operand2  = q.operand2;
  assign bus.operand3  = q.operand3;
  assign bus.operand4  = q.operand4;
  assign bus.imm       = q.imm;
  assign bus.alu_op    = q.alu_op;
  assign bus.funct3    = q.funct3;
  assign bus.jump      = q.jump;
  assign bus.branch    = q.branch;
  assign bus.load      = q.load;
  assign bus.store     = q.store;
  assign bus.word_op   = q.word_op;
  assign bus.ecall     = q.ecall;
  assign bus.ebreak    = q.ebreak;
  assign bus.illegal   = q.illegal;
endmodule
